// File: rtl/cordic_pkg.sv
// cordic_pkg: shared 8Q22 angle constants and width helper for the phase-wrap scheduler.
package cordic_pkg;
   localparam int PD_DEF = 8;
   localparam int P_DEF = 22;
   localparam logic signed [29:0] PI_Q = 30'sd13176794;
   localparam logic signed [29:0] TWO_PI_Q = 30'sd26353589;
   localparam logic signed [29:0] INV_TWO_PI_Q = 30'sd667544;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/cordic_format_sched_phase_wrap_pipe.sv
// phase_wrap_pipe: reduces a pdQp angle into [-pi, pi] over LAT stages; the last
// stage is combinational and lands in the caller's result register.
module phase_wrap_pipe import cordic_pkg::*; #(
   parameter int pd = PD_DEF,
   parameter int p = P_DEF,
   parameter int LAT = 3,
   parameter int IW = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   input  logic [IW-1:0]          i_id,
   input  logic signed [pd+p-1:0] i_angle,
   output logic                   o_valid,
   output logic [IW-1:0]          o_id,
   output logic signed [p+3:0]    o_data
);
   localparam int W = pd + p;
   localparam int W2 = 2 * W;
   localparam int KW = 2 * pd;
   localparam logic signed [W2-1:0] PI_E = W2'(PI_Q);
   localparam logic signed [W2-1:0] TWO_PI_E = W2'(TWO_PI_Q);
   localparam logic signed [W2-1:0] INV_E = W2'(INV_TWO_PI_Q);
   logic signed [W2-1:0] w_prod;
   logic signed [KW-1:0] w_k;
   logic signed [KW-1:0] w_k_o;
   logic signed [W-1:0]  w_x_o;
   logic signed [W2-1:0] w_rem;
   logic signed [W2-1:0] w_wrap;
   assign w_prod = W2'(i_angle) * INV_E;
   // dropping the 2p fraction bits of a signed product is floor(), not truncation toward zero
   assign w_k = w_prod[W2-1:2*p];
   generate
      if (LAT > 1) begin : g_pipe
         localparam int NS = LAT - 1;
         logic [NS-1:0]        r_v;
         logic [IW-1:0]        r_id [NS];
         logic signed [W-1:0]  r_x [NS];
         logic signed [KW-1:0] r_k [NS];
         always_ff @(posedge clk) begin
            r_v <= rst ? '0 : NS'({r_v, i_valid});
            r_id[0] <= i_id;
            r_x[0] <= i_angle;
            r_k[0] <= w_k;
            for (int i = 1; i < NS; i++) begin
               r_id[i] <= r_id[i-1];
               r_x[i] <= r_x[i-1];
               r_k[i] <= r_k[i-1];
            end
         end
         assign o_valid = r_v[NS-1];
         assign o_id = r_id[NS-1];
         assign w_x_o = r_x[NS-1];
         assign w_k_o = r_k[NS-1];
      end else begin : g_comb
         assign o_valid = i_valid;
         assign o_id = i_id;
         assign w_x_o = i_angle;
         assign w_k_o = w_k;
      end
   endgenerate
   assign w_rem = W2'(w_x_o) - W2'(w_k_o) * TWO_PI_E;
   assign w_wrap = (w_rem > PI_E) ? w_rem - TWO_PI_E : w_rem;
   assign o_data = w_wrap[p+3:0];
endmodule

// File: rtl/cordic_format_sched.sv
// cordic_format_sched: round-robin, credit-checked scheduler feeding the phase-wrap
// pipeline into an in-order result FIFO.
module cordic_format_sched import cordic_pkg::*; #(
   parameter int pd = PD_DEF,
   parameter int p = P_DEF,
   parameter int N = 4,
   parameter int LAT = 3,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N-1:0]            req_valid,
   output logic [N-1:0]            req_ready,
   input  logic [N*(pd+p)-1:0]     req_angle,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [p+3:0]     out_data,
   output logic [clog2(N)-1:0]     out_id
);
   localparam int W = pd + p;
   localparam int IW = clog2(N);
   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 2;
   logic [IW-1:0]          r_ptr;
   logic [CW-1:0]          r_inflight;
   logic [CW-1:0]          r_count;
   logic [AW-1:0]          r_wr;
   logic [AW-1:0]          r_rd;
   logic signed [p+3:0]    r_mem_data [DEPTH];
   logic [IW-1:0]          r_mem_id [DEPTH];
   logic [IW-1:0]          w_gnt_id;
   logic [IW-1:0]          w_idx;
   logic                   w_credit;
   logic                   w_gnt;
   logic                   w_push;
   logic                   w_pop;
   logic [IW-1:0]          w_push_id;
   logic signed [p+3:0]    w_push_data;
   logic signed [W-1:0]    w_angle;
   // scanning from the far end lets the requester nearest the pointer win
   always_comb begin
      w_gnt_id = '0;
      w_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         w_idx = IW'((int'(r_ptr) + i) % N);
         if (req_valid[w_idx]) w_gnt_id = w_idx;
      end
   end
   assign w_credit = (r_inflight + r_count) < CW'(DEPTH);
   assign w_gnt = (|req_valid) & w_credit & ~rst;
   assign req_ready = w_gnt ? N'(1) << w_gnt_id : '0;
   assign w_angle = req_angle[int'(w_gnt_id)*W +: W];
   assign out_valid = r_count != '0;
   assign w_pop = out_valid & out_ready;
   assign out_data = out_valid ? r_mem_data[r_rd] : '0;
   assign out_id = out_valid ? r_mem_id[r_rd] : '0;
   phase_wrap_pipe #(.pd(pd), .p(p), .LAT(LAT), .IW(IW)) u_pipe (
      .clk(clk),
      .rst(rst),
      .i_valid(w_gnt),
      .i_id(w_gnt_id),
      .i_angle(w_angle),
      .o_valid(w_push),
      .o_id(w_push_id),
      .o_data(w_push_data)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
         r_inflight <= '0;
         r_count <= '0;
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         r_ptr <= w_gnt ? IW'((int'(w_gnt_id) + 1) % N) : r_ptr;
         r_inflight <= r_inflight + CW'(w_gnt) - CW'(w_push);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         r_wr <= w_push ? r_wr + AW'(1) : r_wr;
         r_rd <= w_pop ? r_rd + AW'(1) : r_rd;
      end
   end
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_data[r_wr] <= w_push_data;
         r_mem_id[r_wr] <= w_push_id;
      end
   end
endmodule

// File: tb/tb_cordic_format_sched.sv
// tb_cordic_format_sched: directed vectors plus randomized traffic checked against a
// transaction-level model of grants, credits and in-order delivery.
module tb_cordic_format_sched;
   localparam int N = 4;
   localparam int W = 30;
   localparam int P = 22;
   localparam int LAT = 3;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*W-1:0]    req_angle;
   logic              out_valid;
   logic              out_ready;
   logic [P+3:0]      out_data;
   logic [1:0]        out_id;

   always #5 clk = ~clk;

   cordic_format_sched dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_angle(req_angle),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_id(out_id)
   );

   int n_chk = 0;
   int n_fail = 0;

   function automatic void check(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic longint ref_reduce(input longint x);
      longint k;
      longint r;
      k = (x * 64'sd667544) >>> 44;
      r = x - k * 64'sd26353589;
      return (r > 64'sd13176794) ? r - 64'sd26353589 : r;
   endfunction

   function automatic longint ang(input int i);
      logic signed [W-1:0] a;
      a = req_angle[i*W +: W];
      return a;
   endfunction

   function automatic logic [W-1:0] rand_ang();
      int s;
      s = $urandom_range(0, 9);
      return (s == 0) ? 30'h20000000 : (s == 1) ? 30'h1FFFFFFF :
             (s == 2) ? W'(13176794) : (s == 3) ? W'(13176795) : W'($urandom);
   endfunction

   typedef struct {int id; longint data; int rdy;} ent_t;
   ent_t q[$];
   int   m_ptr = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;

   // grants are due round-robin while fewer than DEPTH results are owed; results
   // become visible LAT cycles after their grant and leave in grant order
   always @(negedge clk) begin : mon
      int eg;
      bit ev;
      if (mon_en) begin
         if (rst) begin
            q.delete();
            m_ptr = 0;
            check("mon reset req_ready", req_ready, 0);
         end else begin
            ev = (q.size() > 0) && (q[0].rdy <= cyc);
            check("mon out_valid", out_valid, ev);
            check("mon out_data", $signed(out_data), ev ? q[0].data : 0);
            check("mon out_id", out_id, ev ? q[0].id : 0);
            eg = -1;
            if (q.size() < DEPTH)
               for (int i = 0; i < N; i++)
                  if (eg < 0 && req_valid[(m_ptr + i) % N]) eg = (m_ptr + i) % N;
            check("mon req_ready", req_ready, (eg < 0) ? 0 : (1 << eg));
            if (ev && out_ready) void'(q.pop_front());
            if (eg >= 0) begin
               q.push_back('{eg, ref_reduce(ang(eg)), cyc + LAT});
               m_ptr = (eg + 1) % N;
            end
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {int id; longint ang; longint exp;} vec_t;

   initial begin
      vec_t   vecs[9];
      int     lat;
      int     ng;
      int     ids[$];
      int     gids[$];
      longint gdat[$];
      longint dats[$];
      vecs[0] = '{2, 4194304, 4194304};
      vecs[1] = '{0, 16777216, -9576373};
      vecs[2] = '{1, 29360128, 3006539};
      vecs[3] = '{3, -4194304, -4194304};
      vecs[4] = '{0, 0, 0};
      vecs[5] = '{1, 13176794, 13176794};
      vecs[6] = '{2, 13176795, -13176794};
      vecs[7] = '{3, 536870911, 9799131};
      vecs[8] = '{0, -536870912, -9799132};
      rst = 1'b1;
      req_valid = '0;
      req_angle = '0;
      out_ready = 1'b1;
      mon_en = 1'b1;
      tick();
      tick();
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset out_id", out_id, 0);
      rst = 1'b0;

      foreach (vecs[v]) begin
         req_angle[vecs[v].id*W +: W] = W'(vecs[v].ang);
         req_valid = 4'(1) << vecs[v].id;
         @(negedge clk);
         check("tbl grant", req_ready, 1 << vecs[v].id);
         tick();
         req_valid = '0;
         for (lat = 1; lat < 10; lat++) begin
            @(negedge clk);
            if (out_valid) break;
         end
         check("tbl latency", lat, LAT);
         check("tbl data", $signed(out_data), vecs[v].exp);
         check("tbl id", out_id, vecs[v].id);
         tick();
      end

      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) req_angle[i*W +: W] = rand_ang();
      req_valid = '1;
      ids.delete();
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (c < 8) check("fair grant", req_ready, 1 << (c % 4));
         if (out_valid) ids.push_back(int'(out_id));
         tick();
         if (c == 7) req_valid = '0;
      end
      check("fair count", ids.size(), 8);
      foreach (ids[i]) check("fair out_id", ids[i], i % 4);

      out_ready = 1'b0;
      req_valid = '1;
      ng = 0;
      gids.delete();
      gdat.delete();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++)
            if (req_ready[i]) begin
               ng++;
               gids.push_back(i);
               gdat.push_back(ref_reduce(ang(i)));
            end
         tick();
      end
      check("bp grants", ng, DEPTH);
      @(negedge clk);
      check("bp stalled ready", req_ready, 0);
      check("bp full out_valid", out_valid, 1);
      tick();
      req_valid = '0;
      out_ready = 1'b1;
      ids.delete();
      dats.delete();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid) begin
            ids.push_back(int'(out_id));
            dats.push_back($signed(out_data));
         end
         tick();
      end
      check("bp results", ids.size(), DEPTH);
      foreach (ids[i]) begin
         check("bp order id", ids[i], gids[i]);
         check("bp order data", dats[i], gdat[i]);
      end

      out_ready = 1'b0;
      req_valid = '1;
      repeat (8) tick();
      @(negedge clk);
      check("pp full ready", req_ready, 0);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      check("pp pop cycle ready", req_ready, 0);
      check("pp pop cycle valid", out_valid, 1);
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      check("pp one grant", $countones(req_ready), 1);
      tick();
      ng = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         ng += $countones(req_ready);
         tick();
      end
      check("pp refill blocked", ng, 0);
      req_valid = '0;
      out_ready = 1'b1;
      ng = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         ng += int'(out_valid);
         tick();
      end
      check("pp drained", ng, DEPTH);

      out_ready = 1'b0;
      req_valid = '1;
      repeat (4) tick();
      rst = 1'b1;
      req_valid = '0;
      tick();
      rst = 1'b0;
      check("midrst out_valid", out_valid, 0);
      check("midrst out_data", out_data, 0);
      out_ready = 1'b1;
      ng = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         ng += int'(out_valid);
         tick();
      end
      check("midrst stale results", ng, 0);
      req_valid = '1;
      @(negedge clk);
      check("midrst first grant", req_ready, 1);
      tick();
      req_valid = '0;

      for (int c = 0; c < 400; c++) begin
         req_valid = 4'($urandom);
         out_ready = $urandom_range(0, 3) != 0;
         rst = $urandom_range(0, 99) == 0;
         for (int i = 0; i < N; i++) req_angle[i*W +: W] = rand_ang();
         tick();
      end
      rst = 1'b0;
      req_valid = '0;
      out_ready = 1'b1;
      repeat (15) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
